// File: rtl/vga_timing_gen_if.sv
// VGA raster timing bundle: beam position, video qualifier, syncs and markers.
// The timing generator drives it through the master modport, and renderers
// observe it through the slave modport.
interface vga_timing_gen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        line_end;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output DrawX,
    output DrawY,
    output blank,
    output hs,
    output vs,
    output line_end,
    output frame_start,
    output frame_count
  );

  modport slave (
    input DrawX,
    input DrawY,
    input blank,
    input hs,
    input vs,
    input line_end,
    input frame_start,
    input frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480 @ 60 Hz by default).
// DrawX/DrawY are the counter registers. Every decoded output is a register
// loaded from the next-state counter values. Each decoded output therefore
// lines up with the position it describes, and no combinational logic sits
// between the counters and the ports.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // All position compares are done on 10-bit unsigned values.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Counter state
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Registered decodes
  logic blank_q, blank_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic line_end_q, line_end_d;
  logic frame_start_q, frame_start_d;

  // Next-state counters: advance one pixel, wrap line and frame, count frames.
  always_comb begin
    x_d           = x_q + 10'd1;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    // Use >= so that an out-of-range counter recovers at the next wrap
    // instead of running through the full 10-bit range.
    if (x_q >= H_LAST) begin
      x_d = 10'd0;
      if (y_q >= V_LAST) begin
        y_d           = 10'd0;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end else begin
      y_d = y_q;
    end
  end

  // Decode outputs from the next-state position so they register alongside it.
  always_comb begin
    blank_d       = (x_d < H_VIS) && (y_d < V_VIS);
    hs_d          = !((x_d >= HS_START) && (x_d < HS_END));
    line_end_d    = (x_d == H_LAST);
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
    // Vertical sync covers whole lines and updates only at the start of a line.
    if (x_d == 10'd0) begin
      vs_d = !((y_d >= VS_START) && (y_d < VS_END));
    end else begin
      vs_d = vs_q;
    end
  end

  // Counter registers, with synchronous reset to the top-left corner.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      frame_count_q <= 16'd0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Output decode registers; reset blanks the pixel and releases both syncs at once.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.blank       = blank_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.line_end    = line_end_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// One instance runs the full 800x525 raster for the reset, line-wrap and
// hsync tests. A second instance uses a reduced 16x12 raster so that the
// frame-level tests fit in a short run.
// The reduced raster has these sizes:
//   horizontal: 8 visible, 2 front porch, 3 sync, 3 back porch (H_TOTAL 16, hs low for x 10..12)
//   vertical:   6 visible, 2 front porch, 2 sync, 2 back porch (V_TOTAL 12, vs low for y 8..9)
//   frame period: 192 cycles
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_full;
  logic rst_small;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_full ();
  vga_timing_gen_if if_small ();

  vga_timing_gen dut_full (
    .vga_clk (clk),
    .reset   (rst_full),
    .vga     (if_full)
  );

  vga_timing_gen #(
    .H_VISIBLE (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (3),
    .V_VISIBLE (6),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (2)
  ) dut_small (
    .vga_clk (clk),
    .reset   (rst_small),
    .vga     (if_small)
  );

  // Reset held for 3 cycles at an arbitrary position, then the first cycle after release.
  task automatic test_reset();
    rst_full  = 1'b1;
    rst_small = 1'b1;
    repeat (2) @(negedge clk);
    rst_full = 1'b0;
    repeat (37) @(negedge clk);
    rst_full = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (if_full.DrawX !== 10'd0) begin errors++; $display("FAIL reset_drawx got=%0d exp=0", if_full.DrawX); end
    checks++; if (if_full.DrawY !== 10'd0) begin errors++; $display("FAIL reset_drawy got=%0d exp=0", if_full.DrawY); end
    checks++; if (if_full.blank !== 1'b0) begin errors++; $display("FAIL reset_blank got=%b exp=0", if_full.blank); end
    checks++; if (if_full.hs !== 1'b1) begin errors++; $display("FAIL reset_hs got=%b exp=1", if_full.hs); end
    checks++; if (if_full.vs !== 1'b1) begin errors++; $display("FAIL reset_vs got=%b exp=1", if_full.vs); end
    checks++; if (if_full.line_end !== 1'b0) begin errors++; $display("FAIL reset_line_end got=%b exp=0", if_full.line_end); end
    checks++; if (if_full.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b exp=0", if_full.frame_start); end
    checks++; if (if_full.frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got=%0d exp=0", if_full.frame_count); end
    rst_full = 1'b0;
    @(negedge clk);
    checks++; if (if_full.DrawX !== 10'd1) begin errors++; $display("FAIL release_drawx got=%0d exp=1", if_full.DrawX); end
    checks++; if (if_full.DrawY !== 10'd0) begin errors++; $display("FAIL release_drawy got=%0d exp=0", if_full.DrawY); end
    checks++; if (if_full.blank !== 1'b1) begin errors++; $display("FAIL release_blank got=%b exp=1", if_full.blank); end
    checks++; if (if_full.frame_start !== 1'b0) begin errors++; $display("FAIL release_frame_start got=%b exp=0", if_full.frame_start); end
  endtask

  // Line wrap from (799,10) to (0,11), starting from (1,0).
  task automatic test_line_wrap();
    int n;
    n = 0;
    while (!((if_full.DrawX === 10'd799) && (if_full.DrawY === 10'd10)) && (n < 10000)) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 8798) begin errors++; $display("FAIL wrap_reach_cycles got=%0d exp=8798", n); end
    checks++; if (if_full.line_end !== 1'b1) begin errors++; $display("FAIL wrap_line_end_at_799 got=%b exp=1", if_full.line_end); end
    checks++; if (if_full.blank !== 1'b0) begin errors++; $display("FAIL wrap_blank_at_799 got=%b exp=0", if_full.blank); end
    checks++; if (if_full.hs !== 1'b1) begin errors++; $display("FAIL wrap_hs_at_799 got=%b exp=1", if_full.hs); end
    @(negedge clk);
    checks++; if (if_full.DrawX !== 10'd0) begin errors++; $display("FAIL wrap_next_drawx got=%0d exp=0", if_full.DrawX); end
    checks++; if (if_full.DrawY !== 10'd11) begin errors++; $display("FAIL wrap_next_drawy got=%0d exp=11", if_full.DrawY); end
    checks++; if (if_full.blank !== 1'b1) begin errors++; $display("FAIL wrap_next_blank got=%b exp=1", if_full.blank); end
    checks++; if (if_full.line_end !== 1'b0) begin errors++; $display("FAIL wrap_next_line_end got=%b exp=0", if_full.line_end); end
  endtask

  // One full line on line 11, checking position, hs, blank and line_end on every pixel.
  task automatic test_hsync();
    int hs_low;
    int blank_low;
    logic [12:0] got_v;
    logic [12:0] exp_v;
    hs_low    = 0;
    blank_low = 0;
    for (int i = 0; i < 800; i++) begin
      got_v = {if_full.DrawX, if_full.blank, if_full.hs, if_full.line_end};
      exp_v = {10'(i), (i < 640), !((i >= 656) && (i < 752)), (i == 799)};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL hsync_line x=%0d got={x,blank,hs,le}=%h exp=%h", i, got_v, exp_v);
      end
      if (if_full.hs === 1'b0) hs_low++;
      if (if_full.blank === 1'b0) blank_low++;
      @(negedge clk);
    end
    checks++; if (hs_low !== 96) begin errors++; $display("FAIL hsync_low_count got=%0d exp=96", hs_low); end
    checks++; if (blank_low !== 160) begin errors++; $display("FAIL hblank_count got=%0d exp=160", blank_low); end
  endtask

  // Three frames on the reduced raster: every output on every cycle, vs width, frame_start spacing.
  task automatic test_frame_wrap();
    logic [40:0] got_v;
    logic [40:0] exp_v;
    int p;
    int x;
    int y;
    int vs_low;
    int fs_n;
    int fs_k [0:3];
    vs_low = 0;
    fs_n   = 0;
    rst_small = 1'b0;
    for (int k = 1; k <= 580; k++) begin
      @(negedge clk);
      p = k % 192;
      x = p % 16;
      y = p / 16;
      got_v = {if_small.DrawX, if_small.DrawY, if_small.blank, if_small.hs, if_small.vs,
               if_small.line_end, if_small.frame_start, if_small.frame_count};
      exp_v = {10'(x), 10'(y), ((x < 8) && (y < 6)), !((x >= 10) && (x < 13)),
               !((y >= 8) && (y < 10)), (x == 15), (p == 0), 16'(k / 192)};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL frame_walk k=%0d got=%h exp=%h", k, got_v, exp_v);
      end
      if ((k < 192) && (if_small.vs === 1'b0)) vs_low++;
      if ((if_small.frame_start === 1'b1) && (fs_n < 4)) begin
        fs_k[fs_n] = k;
        fs_n++;
      end
    end
    checks++; if (vs_low !== 32) begin errors++; $display("FAIL vsync_low_cycles got=%0d exp=32", vs_low); end
    checks++; if (fs_n !== 3) begin errors++; $display("FAIL frame_start_count got=%0d exp=3", fs_n); end
    if (fs_n == 3) begin
      checks++; if (fs_k[0] !== 192) begin errors++; $display("FAIL first_frame_start_cycle got=%0d exp=192", fs_k[0]); end
      checks++; if ((fs_k[1] - fs_k[0]) !== 192) begin errors++; $display("FAIL frame_spacing_1 got=%0d exp=192", fs_k[1] - fs_k[0]); end
      checks++; if ((fs_k[2] - fs_k[1]) !== 192) begin errors++; $display("FAIL frame_spacing_2 got=%0d exp=192", fs_k[2] - fs_k[1]); end
    end
  endtask

  // Reset inside the sync pulses at (11,9), then the resumed frame.
  task automatic test_midframe_reset();
    int n;
    n = 0;
    while (!((if_small.DrawX === 10'd11) && (if_small.DrawY === 10'd9)) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 151) begin errors++; $display("FAIL mid_reach_cycles got=%0d exp=151", n); end
    checks++; if (if_small.hs !== 1'b0) begin errors++; $display("FAIL mid_hs_before got=%b exp=0", if_small.hs); end
    checks++; if (if_small.vs !== 1'b0) begin errors++; $display("FAIL mid_vs_before got=%b exp=0", if_small.vs); end
    rst_small = 1'b1;
    @(negedge clk);
    checks++; if (if_small.hs !== 1'b1) begin errors++; $display("FAIL mid_hs_after got=%b exp=1", if_small.hs); end
    checks++; if (if_small.vs !== 1'b1) begin errors++; $display("FAIL mid_vs_after got=%b exp=1", if_small.vs); end
    checks++; if (if_small.DrawX !== 10'd0) begin errors++; $display("FAIL mid_drawx_after got=%0d exp=0", if_small.DrawX); end
    checks++; if (if_small.DrawY !== 10'd0) begin errors++; $display("FAIL mid_drawy_after got=%0d exp=0", if_small.DrawY); end
    checks++; if (if_small.frame_count !== 16'd0) begin errors++; $display("FAIL mid_frame_count_after got=%0d exp=0", if_small.frame_count); end
    rst_small = 1'b0;
    n = 0;
    while ((if_small.frame_start !== 1'b1) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 192) begin errors++; $display("FAIL mid_first_frame_start got=%0d exp=192", n); end
    checks++; if (if_small.frame_count !== 16'd1) begin errors++; $display("FAIL mid_frame_count_resume got=%0d exp=1", if_small.frame_count); end
    checks++; if ((if_small.DrawX !== 10'd0) || (if_small.DrawY !== 10'd0)) begin
      errors++; $display("FAIL mid_resume_pos got=(%0d,%0d) exp=(0,0)", if_small.DrawX, if_small.DrawY);
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_line_wrap();
    test_hsync();
    test_frame_wrap();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
